vocab_writer: RTL

- Builds the vocabulary memory that the token matcher scans.
- Accepts a valid/ready byte stream of tokens and writes each token into vocab RAM as consecutive non-zero characters followed by one 0x00 terminator.
- Once the list is sealed, publishes vocab_start_addr and vocab_end_addr (one past the last terminator) for the matcher.
- Sits between the host/loader stream and the write port of the vocab RAM; the matcher owns the read port.

---
 rtl/vocab_writer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/vocab_writer.sv
// vocab_writer
//   Builds the vocabulary memory scanned by the token matcher. A valid/ready
//   byte stream of tokens is written into vocab RAM as consecutive non-zero
//   characters, each token closed by one 0x00 terminator. Once the list is
//   sealed (or runs out of space) the start/end addresses are published.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start, base_addr    begin a new list at base_addr (IDLE/DONE/OVF/ERR only)
//   in_valid, in_data,  character stream; in_last marks the final character
//   in_last, in_ready   of a token; in_ready is combinational
//   seal                close the list, discarding any partial token
//   mem_we, mem_addr,   registered RAM write port, one pulse per write
//   mem_wdata
//   vocab_start_addr    latched base_addr
//   vocab_end_addr      one past the last committed terminator
//   token_count         number of committed tokens
//   busy                list being loaded (LOAD/TERM)
//   done                list closed, by seal or overflow
//   overflow            list truncated for lack of space
//   error               a zero character was received
module vocab_writer #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic                  seal,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [ADDR_WIDTH-1:0] vocab_start_addr,
  output logic [ADDR_WIDTH-1:0] vocab_end_addr,
  output logic [ADDR_WIDTH-1:0] token_count,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic                  error
);

  localparam int PW = ADDR_WIDTH + 1;
  // Highest address a character may be written to: the character and its
  // terminator then end at 2^ADDR_WIDTH-2, so the end address still fits.
  localparam logic [PW-1:0] LIMIT = PW'((2 ** ADDR_WIDTH) - 3);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    TERM,
    DONE,
    OVF,
    ERR
  } state_t;

  state_t                state;
  logic [PW-1:0]         wp;  // next write address (one spare bit for the limit test)
  logic [ADDR_WIDTH-1:0] cp;  // address after the last committed terminator

  // Seal wins over a character offered in the same cycle.
  assign in_ready = (state == LOAD) && !seal;
  assign busy     = (state == LOAD) || (state == TERM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      wp               <= '0;
      cp               <= '0;
      mem_we           <= 1'b0;
      mem_addr         <= '0;
      mem_wdata        <= '0;
      vocab_start_addr <= '0;
      vocab_end_addr   <= '0;
      token_count      <= '0;
      done             <= 1'b0;
      overflow         <= 1'b0;
      error            <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE, DONE, OVF, ERR: begin
          if (start) begin
            vocab_start_addr <= base_addr;
            wp               <= {1'b0, base_addr};
            cp               <= base_addr;
            token_count      <= '0;
            done             <= 1'b0;
            overflow         <= 1'b0;
            error            <= 1'b0;
            state            <= LOAD;
          end
        end
        LOAD: begin
          if (seal) begin
            // Partial token is dropped: the list ends at the last commit.
            vocab_end_addr <= cp;
            done           <= 1'b1;
            state          <= DONE;
          end else if (in_valid) begin
            if (in_data == '0) begin
              error <= 1'b1;
              state <= ERR;
            end else if (wp > LIMIT) begin
              vocab_end_addr <= cp;
              overflow       <= 1'b1;
              done           <= 1'b1;
              state          <= OVF;
            end else begin
              mem_we    <= 1'b1;
              mem_addr  <= wp[ADDR_WIDTH-1:0];
              mem_wdata <= in_data;
              wp        <= wp + PW'(1);
              if (in_last) state <= TERM;
            end
          end
        end
        TERM: begin
          // Terminator lands on the cycle right after the token's last char.
          mem_we      <= 1'b1;
          mem_addr    <= wp[ADDR_WIDTH-1:0];
          mem_wdata   <= '0;
          wp          <= wp + PW'(1);
          cp          <= ADDR_WIDTH'(wp + PW'(1));
          token_count <= token_count + ADDR_WIDTH'(1);
          state       <= LOAD;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
